// File: rtl/keypad_matrix_responder_if.sv
// Keypad emulator bundle: scanner-facing matrix lines, press-command handshake
// and status. "slave" is the emulator side, "master" the scanner/test side.
interface keypad_matrix_responder_if;
  logic [3:0] col;
  logic [3:0] row;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_key;
  logic [7:0] cmd_hold_ms;
  logic       cmd_bounce;
  logic       contact;
  logic       busy;
  logic       done;

  modport slave (
    input  col, cmd_valid, cmd_key, cmd_hold_ms, cmd_bounce,
    output row, cmd_ready, contact, busy, done
  );

  modport master (
    output col, cmd_valid, cmd_key, cmd_hold_ms, cmd_bounce,
    input  row, cmd_ready, contact, busy, done
  );
endinterface

// File: rtl/keypad_matrix_responder.sv
// Synthesizable 4x4 keypad "far end": plays queued key presses (optional contact
// bounce, ms-timed hold, release gap) and answers column strobes on the rows.
module keypad_matrix_responder #(
  parameter int TICK_DIV       = 100000,
  parameter int BOUNCE_HALF    = 500,
  parameter int BOUNCE_TOGGLES = 6,
  parameter int GAP_MS         = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  keypad_matrix_responder_if.slave    kp
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BOUNCE_HALF + 1);
  localparam int TW = $clog2(BOUNCE_TOGGLES + 1);
  localparam int GW = $clog2(GAP_MS + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BOUNCE_HALF - 1);
  localparam logic [TW-1:0] TOG_LAST = TW'(BOUNCE_TOGGLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_IN,
    S_HOLD,
    S_BOUNCE_OUT,
    S_GAP
  } state_e;

  state_e        st_q, st_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    ms_q, ms_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [TW-1:0] tog_q, tog_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    key_q, key_d;
  logic          bnc_q, bnc_d;
  logic          contact_q, contact_d;
  logic [3:0]    row_q, row_d;
  logic          live_q;
  logic          done_w;
  logic          ready_w;
  logic          tick;
  logic          half;

  // cmd_ready must stay low while in reset even though the FSM rests in IDLE.
  assign ready_w = (st_q == S_IDLE) && live_q;
  assign tick    = (pre_q == PRE_LAST);
  assign half    = (bcnt_q == HALF_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= S_IDLE;
      pre_q     <= '0;
      ms_q      <= '0;
      bcnt_q    <= '0;
      tog_q     <= '0;
      gap_q     <= '0;
      key_q     <= '0;
      bnc_q     <= 1'b0;
      contact_q <= 1'b0;
      row_q     <= 4'hF;
      live_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      pre_q     <= pre_d;
      ms_q      <= ms_d;
      bcnt_q    <= bcnt_d;
      tog_q     <= tog_d;
      gap_q     <= gap_d;
      key_q     <= key_d;
      bnc_q     <= bnc_d;
      contact_q <= contact_d;
      row_q     <= row_d;
      live_q    <= 1'b1;
    end
  end

  always_comb begin
    st_d      = st_q;
    pre_d     = tick ? '0 : pre_q + 1'b1;
    ms_d      = ms_q;
    bcnt_d    = bcnt_q;
    tog_d     = tog_q;
    gap_d     = gap_q;
    key_d     = key_q;
    bnc_d     = bnc_q;
    contact_d = contact_q;
    done_w    = 1'b0;

    case (st_q)
      S_IDLE: begin
        contact_d = 1'b0;
        if (kp.cmd_valid && ready_w) begin
          key_d     = kp.cmd_key;
          ms_d      = (kp.cmd_hold_ms == 8'd0) ? 8'd1 : kp.cmd_hold_ms;
          bnc_d     = kp.cmd_bounce;
          bcnt_d    = '0;
          tog_d     = '0;
          contact_d = 1'b1;
          st_d      = kp.cmd_bounce ? S_BOUNCE_IN : S_HOLD;
        end
      end

      S_BOUNCE_IN: begin
        bcnt_d = bcnt_q + 1'b1;
        if (half) begin
          bcnt_d    = '0;
          tog_d     = tog_q + 1'b1;
          contact_d = ~contact_q;
          // The last toggle of an even burst lands closed, i.e. the settled press.
          if (tog_q == TOG_LAST) begin
            st_d      = S_HOLD;
            contact_d = 1'b1;
          end
        end
      end

      S_HOLD: begin
        contact_d = 1'b1;
        if (tick) begin
          if (ms_q <= 8'd1) begin
            ms_d      = '0;
            bcnt_d    = '0;
            tog_d     = '0;
            gap_d     = '0;
            contact_d = 1'b0;
            st_d      = bnc_q ? S_BOUNCE_OUT : S_GAP;
          end else begin
            ms_d = ms_q - 1'b1;
          end
        end
      end

      S_BOUNCE_OUT: begin
        bcnt_d = bcnt_q + 1'b1;
        if (half) begin
          bcnt_d    = '0;
          tog_d     = tog_q + 1'b1;
          contact_d = ~contact_q;
          if (tog_q == TOG_LAST) begin
            st_d      = S_GAP;
            gap_d     = '0;
            contact_d = 1'b0;
          end
        end
      end

      S_GAP: begin
        contact_d = 1'b0;
        if (tick) begin
          if (gap_q == GAP_LAST) begin
            done_w = 1'b1;
            gap_d  = '0;
            st_d   = S_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      default: begin
        st_d      = S_IDLE;
        contact_d = 1'b0;
      end
    endcase

    // Every phase times itself from a fresh ms boundary.
    if (st_d != st_q) pre_d = '0;
  end

  // Only the latched key's row can be pulled low, and only by its own column.
  always_comb begin
    row_d = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_d[r] = ~(contact_q && (key_q[3:2] == 2'(r)) && !kp.col[key_q[1:0]]);
    end
  end

  assign kp.row       = row_q;
  assign kp.cmd_ready = ready_w;
  assign kp.contact   = contact_q;
  assign kp.busy      = (st_q != S_IDLE);
  assign kp.done      = done_w;

endmodule

// File: doc/keypad_matrix_responder.md
Name: keypad_matrix_responder

Overview:
- Behavioural "far end" of the 4x4 matrix keypad interface: a synthesizable keypad emulator.
- Watches the active-low column strobes driven by the keypad scanner and answers on the active-low row lines, as a physical key held down would.
- Key presses are queued one at a time through a valid/ready command port. Each press has a programmable hold time and optional contact bounce.
- Used for on-board self-test and for the bench of the keypad scanner/filter path.

Parameters:
- TICK_DIV, 100000, clk cycles per 1 ms timebase tick (100 MHz clock).
- BOUNCE_HALF, 500, clk cycles per bounce half-period (contact level held between toggles).
- BOUNCE_TOGGLES, 6, number of contact-level toggles in each bounce burst (even; burst ends in the settled level).
- GAP_MS, 2, minimum released time in ms after a release before the next command is accepted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- col  in  4  column strobes from scanner, active-low, one or more low
- row  out  4  row returns to scanner, active-low, registered
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on the cycle where cmd_valid && cmd_ready
- cmd_key  in  4  key index k = 4*r + c (r = row bit, c = column bit)
- cmd_hold_ms  in  8  settled-press duration in ms; 0 treated as 1
- cmd_bounce  in  1  1 = insert bounce bursts at press and at release
- contact  out  1  current emulated contact level (1 = closed)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when GAP finishes

Behaviour:
- Reset is asynchronous and active-low: one clock (clk), reset rst_n; all state clears immediately when rst_n falls. Reset values: row=4'hF, cmd_ready=0 while rst_n low and 1 from the first clk after release, contact=0, busy=0, done=0, FSM=IDLE, all counters 0, tick prescaler 0.
- Row response: row[r] <= ~(contact && (r == key_q[3:2]) && (col[key_q[1:0]] == 0)). Other bits are 1. Latency is 1 clk from a col change or contact change to row.
- Example: key 6 (r=1, c=2) closed, col=4'b1011 -> row=4'b1101. With col=4'b1110 -> row=4'hF.
- Accept: on handshake, latch key_q=cmd_key, hold_q=max(cmd_hold_ms,1), bnc_q=cmd_bounce. Go to BOUNCE_IN if bnc_q, else HOLD. cmd_* are ignored while busy.
- ms tick: the prescaler counts 0..TICK_DIV-1 and is restarted to 0 on every state entry. Tick asserts when the count reaches TICK_DIV-1.
- FSM:
  - IDLE: contact=0. On handshake, transition as described under Accept.
  - BOUNCE_IN: contact toggles every BOUNCE_HALF clks, starting closed on the first cycle. After BOUNCE_TOGGLES toggles go to HOLD (contact=1).
  - HOLD: contact=1. Decrement the ms counter on each tick. When it hits 0, go to BOUNCE_OUT if bnc_q, else GAP.
  - BOUNCE_OUT: contact toggles every BOUNCE_HALF clks, starting open. After BOUNCE_TOGGLES toggles go to GAP (contact=0).
  - GAP: contact=0. Count GAP_MS ticks, pulse done on the final cycle, return to IDLE. cmd_ready rises the cycle after done.
- Settled-closed duration in HOLD = hold_q*TICK_DIV clks exactly (±0).
- A new command presented in the same cycle GAP exits is not accepted until the following cycle (ready=0 during done).
- col with all bits high -> row=4'hF regardless of contact. Multiple col bits low -> the response uses only the latched key's column bit.
- Reset asserted mid-press: row returns to 4'hF asynchronously, no done pulse, the command is lost.
- Counters: ms counter 8-bit, bounce counters sized for the parameters, no wrap possible within a command.

Test Plan:
- Reset, then rst_n=1, col cycling 1110/1101/1011/0111 -> row=4'hF, cmd_ready=1, busy=0.
- Command key=5, hold=3, bounce=0 -> row=4'b1101 only while col=4'b1101, contact high exactly 300000 clks, done pulse after a further 200000 clks.
- Command key=15, hold=1, bounce=1 -> contact toggles 6 times at 500-clk spacing before the settled 100000-clk press, then 6 release toggles, then GAP. row[3] is low only under col=4'b0111 while contact=1.
- hold=0 -> identical timing to hold=1. cmd_valid held high during busy -> exactly one press executed, second accepted one cycle after done.
- rst_n pulsed low mid-HOLD of key 0 with col=4'b1110 -> row=4'hF within the same cycle (async), busy=0, no done.
- Key 6 closed, col=4'b0000 and col=4'b1111 -> row=4'b1101 and row=4'hF respectively, 1 clk after each col change.
